// File: rtl/vec_serializer.sv
// Spreads one packed signed vector over Elements output beats, narrowing each element.
// Define VEC_SERIALIZER_SAT_EN for saturating narrowing; otherwise elements wrap (truncate).
module vec_serializer #(
  parameter  int Elements = 4,
  parameter  int NBitsIn  = 16,
  parameter  int NBitsOut = 8,
  localparam int IdxBits  = (Elements > 1) ? $clog2(Elements) : 1
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic [Elements-1:0][NBitsIn-1:0]  in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic signed [NBitsOut-1:0]        out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [IdxBits-1:0]                out_idx,
  output logic                              out_last
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [IdxBits-1:0] LAST_IDX = IdxBits'(Elements - 1);

`ifdef VEC_SERIALIZER_SAT_EN
  localparam logic signed [NBitsIn-1:0] SAT_MAX =
    {{(NBitsIn - NBitsOut + 1){1'b0}}, {(NBitsOut - 1){1'b1}}};
  localparam logic signed [NBitsIn-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic signed [NBitsOut-1:0] narrow(input logic signed [NBitsIn-1:0] v);
    logic signed [NBitsIn-1:0] c;
    if (v > SAT_MAX)      c = SAT_MAX;
    else if (v < SAT_MIN) c = SAT_MIN;
    else                  c = v;
    return NBitsOut'(c);
  endfunction
`else
  function automatic logic signed [NBitsOut-1:0] narrow(input logic signed [NBitsIn-1:0] v);
    return NBitsOut'(v);
  endfunction
`endif

  state_t                           r_state, w_state_nxt;
  logic [IdxBits-1:0]               r_idx, w_idx_nxt;
  logic [Elements-1:0][NBitsIn-1:0] r_buf;
  logic signed [NBitsIn-1:0]        w_elem;
  logic                             w_out_valid, w_last, w_beat, w_in_ready, w_capture;

  assign w_out_valid = (r_state == SEND);
  assign w_last      = w_out_valid && (r_idx == LAST_IDX);
  assign w_beat      = w_out_valid && out_ready;
  // A vector can be taken while the final beat of the previous one drains.
  assign w_in_ready  = (r_state == IDLE) || (w_beat && w_last);
  assign w_capture   = in_valid && w_in_ready;

  generate
    if (Elements > 1) begin : g_sel
      assign w_elem = r_buf[r_idx];
    end else begin : g_single
      assign w_elem = r_buf[0];
    end
  endgenerate

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_idx   = r_idx;
  assign out_last  = w_last;
  assign out_data  = narrow(w_elem);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (w_capture) begin
      w_state_nxt = SEND;
      w_idx_nxt   = '0;
    end else if (w_beat) begin
      if (w_last) begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end else begin
        w_idx_nxt   = r_idx + IdxBits'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_buf <= '0;
    end else if (w_capture) begin
      r_buf <= in_data;
    end
  end

endmodule

// File: tb/tb_vec_serializer.sv
// Scoreboard bench for vec_serializer: a 4-element instance plus a 1-element instance.
module tb_vec_serializer;

  typedef struct {
    int data;
    int idx;
    int last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-element instance
  logic [3:0][15:0]   in_data;
  logic               in_valid, in_ready, out_valid, out_ready, out_last;
  logic signed [7:0]  out_data;
  logic [1:0]         out_idx;

  // 1-element instance
  logic [0:0][15:0]   in_data1;
  logic               in_valid1, in_ready1, out_valid1, out_ready1, out_last1;
  logic signed [7:0]  out_data1;
  logic [0:0]         out_idx1;

  vec_serializer #(.Elements(4), .NBitsIn(16), .NBitsOut(8)) dut (
    .clk_in(clk), .rst_in(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .out_last(out_last)
  );

  vec_serializer #(.Elements(1), .NBitsIn(16), .NBitsOut(8)) dut1 (
    .clk_in(clk), .rst_in(rst), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_idx(out_idx1), .out_last(out_last1)
  );

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  exp_t exp1_q[$];

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic push4(input int x0, input int x1, input int x2, input int x3);
    exp_t e;
    int xs[4];
    xs = '{x0, x1, x2, x3};
    for (int i = 0; i < 4; i++) begin
      e.data = xs[i];
      e.idx  = i;
      e.last = (i == 3) ? 1 : 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive4(input int e0, input int e1, input int e2, input int e3);
    in_data  = {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
    in_valid = 1'b1;
  endtask

  // Drive one vector, let it drain completely with out_ready high.
  task automatic run_vec(input int e0, input int e1, input int e2, input int e3,
                         input int x0, input int x1, input int x2, input int x3);
    drive4(e0, e1, e2, e3);
    push4(x0, x1, x2, x3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Monitors: pop and compare each accepted beat.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat_idx", int'(out_idx), -1);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", int'(out_data), e.data);
        check("beat_idx", int'(out_idx), e.idx);
        check("beat_last", int'(out_last), e.last);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid1 && out_ready1) begin
      if (exp1_q.size() == 0) begin
        check("unexpected_beat1_data", int'(out_data1), -999);
      end else begin
        e = exp1_q.pop_front();
        check("beat1_data", int'(out_data1), e.data);
        check("beat1_idx", int'(out_idx1), e.idx);
        check("beat1_last", int'(out_last1), e.last);
      end
    end
  end

  initial begin
    exp_t e1;
    rst = 1'b1;
    in_data = '0;   in_valid = 1'b0;  out_ready = 1'b1;
    in_data1 = '0;  in_valid1 = 1'b0; out_ready1 = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_idx", int'(out_idx), 0);
    check("rst_out_last", int'(out_last), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_in_ready1", int'(in_ready1), 1);
    @(posedge clk); #1;

    // Basic vector; in_ready rises only on the last beat
    drive4(1, -2, 3, 127);
    push4(1, -2, 3, 127);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("basic_valid", int'(out_valid), 1);
      check("basic_in_ready", int'(in_ready), (k == 3) ? 1 : 0);
    end
    @(posedge clk); #1;
    check("basic_idle", int'(out_valid), 0);

    // Back-to-back vectors with no bubble
    drive4(4, 5, 6, 7);
    push4(4, 5, 6, 7);
    @(posedge clk); #1;
    drive4(-1, 100, -100, 8);
    push4(-1, 100, -100, 8);
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("b2b_valid", int'(out_valid), 1);
    end
    @(posedge clk); #1;
    check("b2b_idle", int'(out_valid), 0);

    // Backpressure while idx=1
    drive4(1, -2, 3, 127);
    push4(1, -2, 3, 127);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_idx", int'(out_idx), 1);
      check("bp_data", int'(out_data), -2);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_valid", int'(out_valid), 1);
      if (k < 2) @(posedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_idx_4th", int'(out_idx), 1);
    check("bp_data_4th", int'(out_data), -2);
    repeat (3) @(posedge clk);
    #1;

    // Narrowing
`ifdef VEC_SERIALIZER_SAT_EN
    run_vec(300, -200, 0, -1, 127, -128, 0, -1);
`else
    run_vec(300, -200, 0, -1, 44, 56, 0, -1);
`endif

    // Reset mid-vector: only e0 and e1 are accepted before reset
    drive4(9, 10, 11, 12);
    e1.data = 9;  e1.idx = 0; e1.last = 0; exp_q.push_back(e1);
    e1.data = 10; e1.idx = 1; e1.last = 0; exp_q.push_back(e1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_pre_idx", int'(out_idx), 2);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_out_valid", int'(out_valid), 0);
    check("rstmid_in_ready", int'(in_ready), 1);
    check("rstmid_out_idx", int'(out_idx), 0);
    @(posedge clk); #1;
    run_vec(20, 21, 22, 23, 20, 21, 22, 23);

    // Single-element stream
    in_data1  = 16'(5);
    in_valid1 = 1'b1;
    e1.data = 5;  e1.idx = 0; e1.last = 1; exp1_q.push_back(e1);
    @(negedge clk);
    check("single_in_ready_0", int'(in_ready1), 1);
    @(posedge clk); #1;
    in_data1 = 16'(-6);
    e1.data = -6; exp1_q.push_back(e1);
    @(negedge clk);
    check("single_valid_1", int'(out_valid1), 1);
    check("single_in_ready_1", int'(in_ready1), 1);
    @(posedge clk); #1;
    in_data1 = 16'(7);
    e1.data = 7;  exp1_q.push_back(e1);
    @(negedge clk);
    check("single_valid_2", int'(out_valid1), 1);
    check("single_in_ready_2", int'(in_ready1), 1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    check("single_valid_3", int'(out_valid1), 1);
    check("single_in_ready_3", int'(in_ready1), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("single_idle", int'(out_valid1), 0);

    repeat (2) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("queue1_empty", exp1_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
